// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_ctrl_unit buffer.
// Default geometry and the occupancy-counter width function.
package fifo_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_AF_LVL = 6;
  localparam int DEF_AE_LVL = 2;

  // One extra bit so that full and empty never alias.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Storage array for fifo_ctrl_unit.
// Synchronous write port, asynchronous read port, no reset.
module reg_file
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl_unit.sv
// Synchronous show-ahead FIFO with count and almost flags.
// Define FIFO_ERR_EN for sticky overflow/underflow outputs.
module fifo_ctrl_unit
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int AF_LEVEL   = DEF_AF_LVL,
  parameter int AE_LEVEL   = DEF_AE_LVL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  localparam logic AF_RST = (AF_LEVEL == 0);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // A write at full is only taken when a pop frees the slot.
  assign wr_ok = wr && (!full || rd);
  assign rd_ok = rd && !empty;

  // Next occupancy from the accepted accesses.
  always_comb begin
    cnt_nxt = cnt_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt_q + 1'b1;
      2'b01:   cnt_nxt = cnt_q - 1'b1;
      default: cnt_nxt = cnt_q;
    endcase
  end

  // Pointers, count and flags, all registered from next count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      cnt_q        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + 1'b1;
      if (rd_ok) r_ptr <= r_ptr + 1'b1;
      cnt_q        <= cnt_nxt;
      full         <= (cnt_nxt == DEPTH_C);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
    end
  end

`ifdef FIFO_ERR_EN
  // Sticky error flags for dropped accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow <= 1'b1;
      if (rd && empty && !wr) underflow <= 1'b1;
    end
  end
`endif

  assign count = cnt_q;

  reg_file #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(w_ptr),
    .wdata(w_data),
    .raddr(r_ptr),
    .rdata(r_data)
  );

endmodule

// File: tb/tb_fifo_ctrl_unit.sv
// Directed self-checking bench for fifo_ctrl_unit.
// Default parameters; error flags checked when FIFO_ERR_EN is set.
module tb_fifo_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr;
  logic       rd;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
`ifdef FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fifo_ctrl_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr          (wr),
    .rd          (rd),
    .w_data      (w_data),
    .r_data      (r_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`ifdef FIFO_ERR_EN
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic w, input logic r,
                     input logic [7:0] d);
    wr = w;
    rd = r;
    w_data = d;
    tick();
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".ae"}, almost_empty, 1);
    chk({tag, ".af"}, almost_full, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    w_data = '0;
    #12;
    chk_idle("rst");
`ifdef FIFO_ERR_EN
    chk("rst.ovf", overflow, 0);
    chk("rst.unf", underflow, 0);
`endif
    reset_n = 1'b1;
    tick();
    chk_idle("idle");

    // 5,8,2 then one pop
    acc(1, 0, 5);
    chk("w1.count", count, 1);
    chk("w1.ae", almost_empty, 1);
    chk("w1.rdata", r_data, 5);
    acc(1, 0, 8);
    chk("w2.ae", almost_empty, 1);
    acc(1, 0, 2);
    chk("w3.count", count, 3);
    chk("w3.ae", almost_empty, 0);
    chk("w3.rdata", r_data, 5);
    acc(0, 1, 0);
    chk("r1.rdata", r_data, 8);
    chk("r1.count", count, 2);
    chk("r1.ae", almost_empty, 1);
    acc(0, 1, 0);
    acc(0, 1, 0);
    chk("drain.empty", empty, 1);

    // fill 0..7
    for (int i = 0; i < 8; i++) begin
      acc(1, 0, 8'(i));
      chk($sformatf("fill%0d.count", i), count, i + 1);
      chk($sformatf("fill%0d.af", i), almost_full, (i + 1 >= 6));
      chk($sformatf("fill%0d.full", i), full, (i + 1 == 8));
      chk($sformatf("fill%0d.empty", i), empty, 0);
    end
    acc(1, 0, 99);
    chk("ovf.count", count, 8);
    chk("ovf.full", full, 1);
    chk("ovf.rdata", r_data, 0);
`ifdef FIFO_ERR_EN
    chk("ovf.flag", overflow, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rdall%0d", i), r_data, i);
      acc(0, 1, 0);
    end
    chk("rdall.empty", empty, 1);
    chk("rdall.count", count, 0);

    // wrap-around
    for (int i = 0; i < 6; i++) acc(1, 0, 8'(i + 1));
    for (int i = 0; i < 6; i++) acc(0, 1, 0);
    chk("wrap0.empty", empty, 1);
    for (int i = 1; i <= 5; i++) acc(1, 0, 8'(i * 10));
    chk("wrap.count", count, 5);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("wrap%0d", i), r_data, i * 10);
      acc(0, 1, 0);
    end
    chk("wrap.empty", empty, 1);

    // wr&rd while empty
    acc(1, 1, 7);
    chk("se.count", count, 1);
    chk("se.rdata", r_data, 7);
    chk("se.empty", empty, 0);
    acc(0, 1, 0);

    // wr&rd while full
    for (int i = 0; i < 8; i++) acc(1, 0, 8'(100 + i));
    chk("sf.pre", full, 1);
    acc(1, 1, 77);
    chk("sf.count", count, 8);
    chk("sf.full", full, 1);
    chk("sf.rdata", r_data, 101);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("sf%0d", i), r_data, 100 + i);
      acc(0, 1, 0);
    end
    chk("sf.last", r_data, 77);
    acc(0, 1, 0);
    chk("sf.empty", empty, 1);

    // rd while empty
    acc(0, 1, 0);
    chk("unf.count", count, 0);
    chk("unf.empty", empty, 1);
`ifdef FIFO_ERR_EN
    chk("unf.flag", underflow, 1);
`endif
    acc(1, 0, 33);
    chk("unf.wcount", count, 1);
`ifdef FIFO_ERR_EN
    chk("unf.sticky", underflow, 1);
`endif
    acc(1, 0, 34);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_idle("arst");
`ifdef FIFO_ERR_EN
    chk("arst.ovf", overflow, 0);
    chk("arst.unf", underflow, 0);
`endif
    #2;
    reset_n = 1'b1;
    acc(1, 0, 55);
    chk("post.count", count, 1);
    chk("post.rdata", r_data, 55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
